// File: rtl/mem_bus_arbiter_pkg.sv
// Purpose: shared types for the icache/dcache memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: BUS_COMMAND encoding, tag-owner type, memory tag geometry.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } mem_owner_t;

    // Tag 0 means "no tag" on both the response and the return path.
    localparam int MEM_TAG_W = 4;
    localparam int NUM_TAGS  = 1 << MEM_TAG_W;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Purpose: bundles the cache-side, memory-side and return signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: memory refusal is signalled by a zero response tag.
// Modports: slave = arbiter view, master = surrounding caches/memory view.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    BUS_COMMAND             Icache2mem_command;
    logic [63:0]            Icache2mem_addr;
    BUS_COMMAND             Dcache2mem_command;
    logic [63:0]            Dcache2mem_addr;
    logic [63:0]            Dcache2mem_data;
    logic [MEM_TAG_W-1:0]   mem2proc_response;
    logic [MEM_TAG_W-1:0]   mem2proc_tag;
    logic [63:0]            mem2proc_data;

    BUS_COMMAND             proc2mem_command;
    logic [63:0]            proc2mem_addr;
    logic [63:0]            proc2mem_data;
    logic [MEM_TAG_W-1:0]   Imem2proc_response;
    logic [MEM_TAG_W-1:0]   Imem2proc_tag;
    logic [63:0]            Imem2proc_data;
    logic [MEM_TAG_W-1:0]   Dmem2proc_response;
    logic [MEM_TAG_W-1:0]   Dmem2proc_tag;
    logic [63:0]            Dmem2proc_data;
    logic                   stray_tag;

    modport slave (
        input  Icache2mem_command, Icache2mem_addr,
        input  Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        output stray_tag
    );

    modport master (
        output Icache2mem_command, Icache2mem_addr,
        output Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        input  stray_tag
    );

endinterface

// File: rtl/mem_tag_owner_table.sv
// Purpose: remembers which cache owns each outstanding memory load tag.
// Latency: lookup is combinational; set/clear take effect at the next clock edge.
// Backpressure: none; set and clear are accepted every cycle, set wins on the same tag.
// Ports: clock/reset, set_en/set_tag/set_owner, clr_en/clr_tag, lookup_tag -> hit/owner.
module mem_tag_owner_table
    import mem_bus_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [MEM_TAG_W-1:0]  set_tag,
    input  mem_owner_t            set_owner,
    input  logic                  clr_en,
    input  logic [MEM_TAG_W-1:0]  clr_tag,
    input  logic [MEM_TAG_W-1:0]  lookup_tag,
    output logic                  hit,
    output mem_owner_t            owner
);

    logic [NUM_TAGS-1:0] valid_q;
    mem_owner_t          owner_q [NUM_TAGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                owner_q[i] <= OWNER_ICACHE;
            end
        end else begin
            // Clear first, then set: a tag returning and being reissued in
            // the same cycle ends up valid with the new owner.
            if (clr_en) begin
                valid_q[clr_tag] <= 1'b0;
            end
            if (set_en) begin
                valid_q[set_tag] <= 1'b1;
                owner_q[set_tag] <= set_owner;
            end
        end
    end

    assign hit   = valid_q[lookup_tag];
    assign owner = owner_q[lookup_tag];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares the memory port between icache and dcache and routes load returns to their owner.
// Latency: command/response path 0 cycles (combinational); tag ownership registered.
// Backpressure: none held; a refused command (response 0) is reported to the granted cache only.
// Ports: clock, reset (sync, active-high), bus (mem_bus_arbiter_if.slave).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic                    clock,
    input  logic                    reset,
    mem_bus_arbiter_if.slave        bus
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             icache_req;
    logic             dcache_req;
    logic             grant_icache;
    logic             grant_dcache;
    logic             accepted;
    logic             ret_vld;
    logic             tbl_hit;
    mem_owner_t       tbl_owner;
    logic             set_en;

    assign icache_req = bus.Icache2mem_command != BUS_NONE;
    assign dcache_req = bus.Dcache2mem_command != BUS_NONE;
    assign accepted   = bus.mem2proc_response != '0;

    // dcache normally wins; a starved icache takes one grant once the limit is hit.
    assign grant_icache = !reset && icache_req && (!dcache_req || starve_cnt >= LIMIT);
    assign grant_dcache = !reset && dcache_req && !grant_icache;

    always_comb begin
        bus.proc2mem_command   = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Imem2proc_response = '0;
        bus.Dmem2proc_response = '0;
        if (grant_icache) begin
            bus.proc2mem_command   = bus.Icache2mem_command;
            bus.proc2mem_addr      = bus.Icache2mem_addr;
            bus.Imem2proc_response = bus.mem2proc_response;
        end else if (grant_dcache) begin
            bus.proc2mem_command   = bus.Dcache2mem_command;
            bus.proc2mem_addr      = bus.Dcache2mem_addr;
            bus.proc2mem_data      = bus.Dcache2mem_data;
            bus.Dmem2proc_response = bus.mem2proc_response;
        end
    end

    // Only accepted loads get an owner entry; stores never return a tag.
    assign set_en = (grant_icache || grant_dcache) && bus.proc2mem_command == BUS_LOAD && accepted;

    assign ret_vld = !reset && bus.mem2proc_tag != '0;

    mem_tag_owner_table u_owner_table (
        .clock      (clock),
        .reset      (reset),
        .set_en     (set_en),
        .set_tag    (bus.mem2proc_response),
        .set_owner  (grant_icache ? OWNER_ICACHE : OWNER_DCACHE),
        .clr_en     (ret_vld),
        .clr_tag    (bus.mem2proc_tag),
        .lookup_tag (bus.mem2proc_tag),
        .hit        (tbl_hit),
        .owner      (tbl_owner)
    );

    // Routing uses the owner as it stands before this cycle's update.
    assign bus.Imem2proc_tag  = (ret_vld && tbl_hit && tbl_owner == OWNER_ICACHE) ? bus.mem2proc_tag : '0;
    assign bus.Dmem2proc_tag  = (ret_vld && tbl_hit && tbl_owner == OWNER_DCACHE) ? bus.mem2proc_tag : '0;
    assign bus.Imem2proc_data = bus.mem2proc_data;
    assign bus.Dmem2proc_data = bus.mem2proc_data;
    assign bus.stray_tag      = ret_vld && !tbl_hit;

    // A refused icache grant neither counts as a denial nor clears the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (icache_req && !grant_icache) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (grant_icache && accepted) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter (directed cases plus random traffic vs a model).
// Latency: expects 0-cycle command/response path and next-edge ownership updates.
// Backpressure: exercises memory refusals (response 0) and stray returns.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int STARVE = 4;

    logic        clock;
    logic        reset;
    BUS_COMMAND  icmd, dcmd;
    logic [63:0] iaddr, daddr, ddata, mdata;
    logic [3:0]  resp, tag;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter_if bus();

    assign bus.Icache2mem_command = icmd;
    assign bus.Icache2mem_addr    = iaddr;
    assign bus.Dcache2mem_command = dcmd;
    assign bus.Dcache2mem_addr    = daddr;
    assign bus.Dcache2mem_data    = ddata;
    assign bus.mem2proc_response  = resp;
    assign bus.mem2proc_tag       = tag;
    assign bus.mem2proc_data      = mdata;

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        icmd  = BUS_NONE;
        dcmd  = BUS_NONE;
        iaddr = '0;
        daddr = '0;
        ddata = '0;
        resp  = '0;
        tag   = '0;
        mdata = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    // Reference model: outstanding tags as plain arrays (1 = icache, 2 = dcache)
    // and the count of consecutive icache denials as an unbounded integer.
    bit m_valid [16];
    int m_owner [16];
    int m_starve = 0;

    always @(negedge clock) begin : model_cmp
        int          win;
        bit          ireq, dreq;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr, e_data;
        logic [3:0]  e_ir, e_dr, e_it, e_dt;
        logic        e_stray;

        ireq = icmd != BUS_NONE;
        dreq = dcmd != BUS_NONE;
        win  = 0;
        if (!reset) begin
            if (ireq && dreq) win = (m_starve >= STARVE) ? 1 : 2;
            else if (ireq)    win = 1;
            else if (dreq)    win = 2;
        end
        e_cmd  = (win == 1) ? icmd : (win == 2) ? dcmd : BUS_NONE;
        e_addr = (win == 1) ? iaddr : daddr;
        e_data = (win == 2) ? ddata : 64'h0;
        e_ir   = (win == 1) ? resp : 4'h0;
        e_dr   = (win == 2) ? resp : 4'h0;
        e_it   = 4'h0;
        e_dt   = 4'h0;
        e_stray = 1'b0;
        if (!reset && tag != 0) begin
            if (m_valid[tag]) begin
                if (m_owner[tag] == 1) e_it = tag;
                else                   e_dt = tag;
            end else begin
                e_stray = 1'b1;
            end
        end

        chk("m_cmd", bus.proc2mem_command, e_cmd);
        if (win != 0) begin
            chk("m_addr", bus.proc2mem_addr, e_addr);
            chk("m_data", bus.proc2mem_data, e_data);
        end
        chk("m_iresp", bus.Imem2proc_response, e_ir);
        chk("m_dresp", bus.Dmem2proc_response, e_dr);
        chk("m_itag",  bus.Imem2proc_tag, e_it);
        chk("m_dtag",  bus.Dmem2proc_tag, e_dt);
        chk("m_stray", bus.stray_tag, e_stray);
        if (e_it != 0) chk("m_idata", bus.Imem2proc_data, mdata);
        if (e_dt != 0) chk("m_ddata", bus.Dmem2proc_data, mdata);

        // State as it will be after the coming clock edge.
        if (reset) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_starve = 0;
        end else begin
            if (tag != 0) m_valid[tag] = 1'b0;
            if (win != 0 && e_cmd == BUS_LOAD && resp != 0) begin
                m_valid[resp] = 1'b1;
                m_owner[resp] = win;
            end
            if (ireq && win != 1)            m_starve++;
            else if (win == 1 && resp != 0)  m_starve = 0;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_owner[i] = 0;
        end
        idle();
        reset = 1'b1;

        // Busy inputs during reset must not leak through.
        icmd = BUS_LOAD; iaddr = 64'h55; dcmd = BUS_STORE; resp = 4'd3; tag = 4'd3;
        settle();
        chk("rst_cmd",   bus.proc2mem_command, BUS_NONE);
        chk("rst_iresp", bus.Imem2proc_response, 0);
        chk("rst_dresp", bus.Dmem2proc_response, 0);
        chk("rst_itag",  bus.Imem2proc_tag, 0);
        chk("rst_dtag",  bus.Dmem2proc_tag, 0);
        chk("rst_stray", bus.stray_tag, 0);
        tick();
        reset = 1'b0;
        idle();

        // icache load alone, later return of its tag.
        icmd = BUS_LOAD; iaddr = 64'h100; resp = 4'd3;
        settle();
        chk("t1_addr",  bus.proc2mem_addr, 64'h100);
        chk("t1_cmd",   bus.proc2mem_command, BUS_LOAD);
        chk("t1_iresp", bus.Imem2proc_response, 3);
        chk("t1_dresp", bus.Dmem2proc_response, 0);
        tick();
        idle(); tag = 4'd3; mdata = 64'hDEAD;
        settle();
        chk("t1_itag",  bus.Imem2proc_tag, 3);
        chk("t1_idata", bus.Imem2proc_data, 64'hDEAD);
        chk("t1_dtag",  bus.Dmem2proc_tag, 0);
        chk("t1_stray", bus.stray_tag, 0);
        tick();
        idle();

        // dcache store: no owner entry, so its tag coming back is a stray.
        dcmd = BUS_STORE; daddr = 64'h3000; ddata = 64'hBEEF; resp = 4'd5;
        settle();
        chk("t3_dresp", bus.Dmem2proc_response, 5);
        chk("t3_data",  bus.proc2mem_data, 64'hBEEF);
        chk("t3_iresp", bus.Imem2proc_response, 0);
        tick();
        idle(); tag = 4'd5; mdata = 64'h55;
        settle();
        chk("t3_itag",  bus.Imem2proc_tag, 0);
        chk("t3_dtag",  bus.Dmem2proc_tag, 0);
        chk("t3_stray", bus.stray_tag, 1);
        tick();
        idle();
        settle();
        chk("t3_stray_pulse", bus.stray_tag, 0);
        tick();

        // Both loading every cycle: d,d,d,d,i,d.
        for (int c = 0; c < 6; c++) begin
            icmd = BUS_LOAD; iaddr = 64'h1000 + 64'(c);
            dcmd = BUS_LOAD; daddr = 64'h2000 + 64'(c);
            resp = 4'(c + 1);
            settle();
            chk("t2_grant", bus.proc2mem_addr, (c == 4) ? 64'h1000 + 64'(c) : 64'h2000 + 64'(c));
            tick();
        end
        idle();

        // Tag 7 returns to icache while dcache is handed tag 7 in the same cycle.
        icmd = BUS_LOAD; iaddr = 64'h700; resp = 4'd7;
        settle();
        chk("t4_iresp", bus.Imem2proc_response, 7);
        tick();
        idle(); dcmd = BUS_LOAD; daddr = 64'h2700; resp = 4'd7; tag = 4'd7; mdata = 64'h7777;
        settle();
        chk("t4_itag",  bus.Imem2proc_tag, 7);
        chk("t4_dtag",  bus.Dmem2proc_tag, 0);
        chk("t4_dresp", bus.Dmem2proc_response, 7);
        chk("t4_idata", bus.Imem2proc_data, 64'h7777);
        tick();
        idle(); tag = 4'd7; mdata = 64'h8888;
        settle();
        chk("t4_dtag_later", bus.Dmem2proc_tag, 7);
        chk("t4_itag_later", bus.Imem2proc_tag, 0);
        tick();
        idle();

        // Two denials, then a refused icache grant that must leave the count at 2.
        for (int c = 0; c < 2; c++) begin
            icmd = BUS_LOAD; iaddr = 64'h1600; dcmd = BUS_LOAD; daddr = 64'h2600; resp = 4'd0;
            settle();
            chk("t6_pre", bus.proc2mem_addr, 64'h2600);
            tick();
        end
        idle(); icmd = BUS_LOAD; iaddr = 64'h600; resp = 4'd0;
        settle();
        chk("t6_cmd",   bus.proc2mem_command, BUS_LOAD);
        chk("t6_addr",  bus.proc2mem_addr, 64'h600);
        chk("t6_iresp", bus.Imem2proc_response, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            icmd = BUS_LOAD; iaddr = 64'h1610; dcmd = BUS_LOAD; daddr = 64'h2610; resp = 4'd0;
            settle();
            chk("t6_post", bus.proc2mem_addr, (c == 2) ? 64'h1610 : 64'h2610);
            tick();
        end
        idle();

        // Reset forgets an outstanding dcache load.
        dcmd = BUS_LOAD; daddr = 64'h2200; resp = 4'd2;
        settle();
        chk("t5_dresp", bus.Dmem2proc_response, 2);
        tick();
        idle(); reset = 1'b1;
        tick();
        reset = 1'b0; tag = 4'd2; mdata = 64'h2222;
        settle();
        chk("t5_stray", bus.stray_tag, 1);
        chk("t5_dtag",  bus.Dmem2proc_tag, 0);
        chk("t5_itag",  bus.Imem2proc_tag, 0);
        tick();
        idle();

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            icmd  = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
            dcmd  = BUS_COMMAND'(2'($urandom_range(0, 2)));
            iaddr = {$urandom, $urandom};
            daddr = {$urandom, $urandom};
            ddata = {$urandom, $urandom};
            resp  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tag   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mdata = {$urandom, $urandom};
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
